// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and lane helpers for the load/store alignment engine
//   SZ_*    : access size encodings (log2 of bytes)
//   state_t : alignment FSM state encoding
//   nb_of   : byte lanes for a given bus width
//   ow_of   : lane offset width for a given bus width
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD0 = 3'd1,
    RD0  = 3'd2,
    CMD1 = 3'd3,
    RD1  = 3'd4,
    RESP = 3'd5
  } state_t;

  function automatic int nb_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int ow_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_align_unit_if.sv
// rtl/mem_align_unit_if.sv - request, memory-bus and response signals of the alignment engine
//   req_* : datapath request handshake (valid/ready) with size, sign, address, store data
//   bus_* : lane-aligned data-memory beats (valid/ready) and read return (rvalid/rdata)
//   rsp_* : one-cycle completion pulse with extended load data and error flag
//   slave : the alignment engine side; master : datapath plus memory side
interface mem_align_unit_if
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = nb_of(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [NB-1:0]     bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  bus_ready, bus_rvalid, bus_rdata,
    output req_ready, bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output bus_ready, bus_rvalid, bus_rdata,
    input  req_ready, bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_lane_ext.sv
// rtl/mem_lane_ext.sv - combinational load extraction with sign/zero extension
//   rdata2 : {beat1, beat0} read data, 2*DATA_W bits
//   off    : byte offset of the access within the first beat
//   size   : log2 of access bytes
//   sgn    : 1 = sign-extend, 0 = zero-extend
//   data   : right-justified extended load data
module mem_lane_ext
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OW     = ow_of(DATA_W)
) (
  input  logic [2*DATA_W-1:0] rdata2,
  input  logic [OW-1:0]       off,
  input  logic [1:0]          size,
  input  logic                sgn,
  output logic [DATA_W-1:0]   data
);

  logic [DATA_W-1:0] lo;
  logic              msb;
  int                nbits;

  always_comb begin
    lo    = DATA_W'(rdata2 >> {off, 3'b000});
    nbits = 8 << size;
    // Sizes at or above the bus width pass the shifted data unchanged.
    if (nbits > DATA_W) nbits = DATA_W;
    case (size)
      SZ_B:    msb = lo[7];
      SZ_H:    msb = lo[15];
      SZ_W:    msb = lo[31];
      default: msb = lo[DATA_W-1];
    endcase
    data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data[i] = (i < nbits) ? lo[i] : (sgn & msb);
    end
  end

endmodule

// File: rtl/mem_align_unit.sv
// rtl/mem_align_unit.sv - load/store alignment engine between datapath and data-memory bus
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   io         : request handshake, memory-bus beats and response (mem_align_unit_if.slave)
// Lane-crossing accesses become two beats (SPLIT_EN=1) or an error response (SPLIT_EN=0).
module mem_align_unit
  import mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SPLIT_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_align_unit_if.slave   io
);

  localparam int NB = nb_of(DATA_W);
  localparam int OW = ow_of(DATA_W);

  state_t state, state_nx;

  // Latched request and precomputed beats
  logic              we_q, sgn_q, cross_q, err_q;
  logic [1:0]        size_q;
  logic [OW-1:0]     off_q;
  logic [ADDR_W-1:0] base_q;
  logic [NB-1:0]     be0_q, be1_q;
  logic [DATA_W-1:0] wd0_q, wd1_q, r0_q, r1_q;

  // Request decode
  logic [OW-1:0]       off_in;
  logic [2*NB-1:0]     one2, mask2;
  logic [2*DATA_W-1:0] wide;
  logic                cross_in, err_in;
  logic [DATA_W-1:0]   ext;

  always_comb begin
    off_in   = io.req_addr[OW-1:0];
    one2     = {{(2*NB-1){1'b0}}, 1'b1};
    // For the widest size the shift wraps to 0 and the subtraction yields all ones.
    mask2    = ((one2 << (4'd1 << io.req_size)) - one2) << off_in;
    wide     = {{DATA_W{1'b0}}, io.req_wdata} << {off_in, 3'b000};
    cross_in = |mask2[2*NB-1:NB];
    err_in   = (int'(io.req_size) > OW) || (cross_in && (SPLIT_EN == 0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      base_q  <= '0;
      be0_q   <= '0;
      be1_q   <= '0;
      wd0_q   <= '0;
      wd1_q   <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
    end else begin
      if (state == IDLE && io.req_valid) begin
        we_q    <= io.req_we;
        sgn_q   <= io.req_signed;
        cross_q <= cross_in;
        err_q   <= err_in;
        size_q  <= io.req_size;
        off_q   <= off_in;
        base_q  <= {io.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
        be0_q   <= mask2[NB-1:0];
        be1_q   <= mask2[2*NB-1:NB];
        wd0_q   <= wide[DATA_W-1:0];
        wd1_q   <= wide[2*DATA_W-1:DATA_W];
        r0_q    <= '0;
        r1_q    <= '0;
      end
      if (state == RD0 && io.bus_rvalid) r0_q <= io.bus_rdata;
      if (state == RD1 && io.bus_rvalid) r1_q <= io.bus_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  mem_lane_ext #(.DATA_W(DATA_W)) u_ext (
    .rdata2 ({r1_q, r0_q}),
    .off    (off_q),
    .size   (size_q),
    .sgn    (sgn_q),
    .data   (ext)
  );

  always_comb begin
    state_nx     = state;
    io.req_ready = 1'b0;
    io.bus_valid = 1'b0;
    io.bus_we    = 1'b0;
    io.bus_addr  = '0;
    io.bus_be    = '0;
    io.bus_wdata = '0;
    io.rsp_valid = 1'b0;
    io.rsp_rdata = '0;
    io.rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        io.req_ready = rst_n;
        if (io.req_valid) state_nx = err_in ? RESP : CMD0;
      end
      CMD0: begin
        io.bus_valid = 1'b1;
        io.bus_we    = we_q;
        io.bus_addr  = base_q;
        io.bus_be    = be0_q;
        io.bus_wdata = wd0_q;
        if (io.bus_ready) state_nx = !we_q ? RD0 : (cross_q ? CMD1 : RESP);
      end
      RD0: begin
        if (io.bus_rvalid) state_nx = cross_q ? CMD1 : RESP;
      end
      CMD1: begin
        io.bus_valid = 1'b1;
        io.bus_we    = we_q;
        io.bus_addr  = base_q + ADDR_W'(NB);
        io.bus_be    = be1_q;
        io.bus_wdata = wd1_q;
        if (io.bus_ready) state_nx = we_q ? RESP : RD1;
      end
      RD1: begin
        if (io.bus_rvalid) state_nx = RESP;
      end
      RESP: begin
        io.rsp_valid = 1'b1;
        io.rsp_err   = err_q;
        io.rsp_rdata = (we_q || err_q) ? '0 : ext;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_align_unit.sv
// tb/tb_mem_align_unit.sv - directed self-checking bench for mem_align_unit
module tb_mem_align_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_align_unit_if #(.DATA_W(32), .ADDR_W(32)) ia ();
  mem_align_unit_if #(.DATA_W(32), .ADDR_W(32)) ib ();

  mem_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ia)
  );

  mem_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(0)) u_dut_ns (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ib)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata);
    chk("req_ready_before", ia.req_ready, 1);
    ia.req_valid  = 1'b1;
    ia.req_we     = we;
    ia.req_size   = size;
    ia.req_signed = sgn;
    ia.req_addr   = addr;
    ia.req_wdata  = wdata;
    tick();
    ia.req_valid  = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic we, input logic [31:0] rd,
                      input int stall);
    chk({tag, ".valid"}, ia.bus_valid, 1);
    chk({tag, ".we"},    ia.bus_we,    we);
    chk({tag, ".addr"},  ia.bus_addr,  addr);
    chk({tag, ".be"},    ia.bus_be,    be);
    chk({tag, ".wdata"}, ia.bus_wdata, wd);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, ".stall_valid"}, ia.bus_valid, 1);
      chk({tag, ".stall_addr"},  ia.bus_addr,  addr);
      chk({tag, ".stall_be"},    ia.bus_be,    be);
      chk({tag, ".stall_wdata"}, ia.bus_wdata, wd);
    end
    ia.bus_ready = 1'b1;
    tick();
    ia.bus_ready = 1'b0;
    if (!we) begin
      chk({tag, ".rd_wait_idle"}, ia.bus_valid, 0);
      ia.bus_rvalid = 1'b1;
      ia.bus_rdata  = rd;
      tick();
      ia.bus_rvalid = 1'b0;
      ia.bus_rdata  = 32'h0;
    end
  endtask

  task automatic rsp(input string tag, input logic [31:0] rdata, input logic err);
    chk({tag, ".rsp_valid"}, ia.rsp_valid, 1);
    chk({tag, ".rsp_rdata"}, ia.rsp_rdata, rdata);
    chk({tag, ".rsp_err"},   ia.rsp_err,   err);
    chk({tag, ".bus_idle"},  ia.bus_valid, 0);
    tick();
    chk({tag, ".rsp_pulse"}, ia.rsp_valid, 0);
    chk({tag, ".ready_after"}, ia.req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ia.req_valid = 0; ia.req_we = 0; ia.req_size = 0; ia.req_signed = 0;
    ia.req_addr = 0; ia.req_wdata = 0; ia.bus_ready = 0; ia.bus_rvalid = 0; ia.bus_rdata = 0;
    ib.req_valid = 0; ib.req_we = 0; ib.req_size = 0; ib.req_signed = 0;
    ib.req_addr = 0; ib.req_wdata = 0; ib.bus_ready = 0; ib.bus_rvalid = 0; ib.bus_rdata = 0;

    // Reset state
    tick();
    tick();
    chk("rst.req_ready", ia.req_ready, 0);
    chk("rst.bus_valid", ia.bus_valid, 0);
    chk("rst.bus_addr",  ia.bus_addr,  0);
    chk("rst.rsp_valid", ia.rsp_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst.req_ready", ia.req_ready, 1);

    // Store byte at lane 3
    req(1, 2'd0, 0, 32'h0000_1003, 32'h0000_00AB);
    beat("sb", 32'h0000_1000, 4'b1000, 32'hAB00_0000, 1, 0, 0);
    rsp("sb", 32'h0, 0);

    // Store half with 3 stall cycles
    req(1, 2'd1, 0, 32'h0000_2002, 32'h0000_1234);
    beat("sh", 32'h0000_2000, 4'b1100, 32'h1234_0000, 1, 0, 3);
    rsp("sh", 32'h0, 0);

    // Load byte signed / unsigned
    req(0, 2'd0, 1, 32'h0000_3001, 32'h0);
    beat("lbs", 32'h0000_3000, 4'b0010, 32'h0, 0, 32'h0000_80FF, 0);
    rsp("lbs", 32'hFFFF_FF80, 0);
    req(0, 2'd0, 0, 32'h0000_3001, 32'h0);
    beat("lbu", 32'h0000_3000, 4'b0010, 32'h0, 0, 32'h0000_80FF, 0);
    rsp("lbu", 32'h0000_0080, 0);

    // Signed half, signed full word
    req(0, 2'd1, 1, 32'h0000_2002, 32'h0);
    beat("lhs", 32'h0000_2000, 4'b1100, 32'h0, 0, 32'h8001_5555, 0);
    rsp("lhs", 32'hFFFF_8001, 0);
    req(0, 2'd2, 1, 32'h0000_5000, 32'h0);
    beat("lw", 32'h0000_5000, 4'b1111, 32'h0, 0, 32'h8765_4321, 0);
    rsp("lw", 32'h8765_4321, 0);

    // Split word load
    req(0, 2'd2, 0, 32'h0000_4003, 32'h0);
    beat("slw0", 32'h0000_4000, 4'b1000, 32'h0, 0, 32'h1122_3344, 0);
    beat("slw1", 32'h0000_4004, 4'b0111, 32'h0, 0, 32'h5566_7788, 0);
    rsp("slw", 32'h6677_8811, 0);

    // Split word store
    req(1, 2'd2, 0, 32'h0000_4002, 32'hAABB_CCDD);
    beat("ssw0", 32'h0000_4000, 4'b1100, 32'hCCDD_0000, 1, 0, 0);
    beat("ssw1", 32'h0000_4004, 4'b0011, 32'h0000_AABB, 1, 0, 0);
    rsp("ssw", 32'h0, 0);

    // Split load wrapping the top of the address space
    req(0, 2'd2, 0, 32'hFFFF_FFFE, 32'h0);
    beat("wrap0", 32'hFFFF_FFFC, 4'b1100, 32'h0, 0, 32'hBEEF_0000, 0);
    beat("wrap1", 32'h0000_0000, 4'b0011, 32'h0, 0, 32'h0000_CAFE, 0);
    rsp("wrap", 32'hCAFE_BEEF, 0);

    // Illegal size on the split-enabled unit
    req(0, 2'd3, 0, 32'h0000_5000, 32'h0);
    rsp("sz3", 32'h0, 1);

    // SPLIT_EN=0: crossing store and illegal size both error, no bus activity
    chk("ns.ready", ib.req_ready, 1);
    ib.req_valid = 1; ib.req_we = 1; ib.req_size = 2'd2; ib.req_addr = 32'h0000_4002;
    ib.req_wdata = 32'h1234_5678;
    tick();
    ib.req_valid = 0;
    chk("ns_cross.rsp_valid", ib.rsp_valid, 1);
    chk("ns_cross.rsp_err",   ib.rsp_err,   1);
    chk("ns_cross.bus_valid", ib.bus_valid, 0);
    tick();
    chk("ns_cross.rsp_pulse", ib.rsp_valid, 0);
    chk("ns_cross.bus_idle",  ib.bus_valid, 0);
    ib.req_valid = 1; ib.req_we = 0; ib.req_size = 2'd3; ib.req_addr = 32'h0000_5000;
    tick();
    ib.req_valid = 0;
    chk("ns_sz3.rsp_valid", ib.rsp_valid, 1);
    chk("ns_sz3.rsp_err",   ib.rsp_err,   1);
    chk("ns_sz3.rsp_rdata", ib.rsp_rdata, 0);
    chk("ns_sz3.bus_valid", ib.bus_valid, 0);
    tick();

    // Reset during CMD1 of a split store
    req(1, 2'd2, 0, 32'h0000_4002, 32'hAABB_CCDD);
    beat("rs0", 32'h0000_4000, 4'b1100, 32'hCCDD_0000, 1, 0, 0);
    chk("rs.cmd1_valid", ia.bus_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rs.bus_valid", ia.bus_valid, 0);
    chk("rs.bus_be",    ia.bus_be,    0);
    chk("rs.bus_addr",  ia.bus_addr,  0);
    chk("rs.bus_wdata", ia.bus_wdata, 0);
    chk("rs.req_ready", ia.req_ready, 0);
    chk("rs.rsp_valid", ia.rsp_valid, 0);
    tick();
    chk("rs.rsp_hold", ia.rsp_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("rs.rsp_after", ia.rsp_valid, 0);
    req(1, 2'd2, 0, 32'h0000_6000, 32'hDEAD_BEEF);
    beat("rsw", 32'h0000_6000, 4'b1111, 32'hDEAD_BEEF, 1, 0, 0);
    rsp("rsw", 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
- Parametrised load/store alignment engine between the multicycle datapath and the data-memory bus.
- Generalises the byte-enable generator to DATA_W/8 lanes and all access sizes.
- Adds write-data lane steering, load extraction with sign/zero extension, and splitting of lane-crossing accesses into two bus beats.
- Accepts one request at a time through a valid/ready handshake and returns one response.

Parameters:
- DATA_W, 32, bus and register width in bits; power of two, 32 or 64.
- ADDR_W, 32, byte address width.
- SPLIT_EN, 1, 1 = lane-crossing accesses are split into two beats; 0 = such accesses return rsp_err.
- NB (localparam), DATA_W/8, number of byte lanes. OW (localparam), log2(NB), offset width.

Ports:
- clk in 1: system clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- req_valid in 1: request present.
- req_ready out 1: unit can accept a request.
- req_we in 1: 1 = store, 0 = load.
- req_size in 2: log2 of access bytes (0 = byte, 1 = half, 2 = word, 3 = dword).
- req_signed in 1: load sign-extends when 1.
- req_addr in ADDR_W: byte address.
- req_wdata in DATA_W: store data, right-justified.
- bus_valid out 1: beat command valid.
- bus_ready in 1: memory accepts the beat.
- bus_we out 1: beat is a write.
- bus_addr out ADDR_W: lane-aligned address; low OW bits are 0.
- bus_be out NB: byte enables.
- bus_wdata out DATA_W: lane-steered write data.
- bus_rvalid in 1: read data valid for the oldest accepted read beat.
- bus_rdata in DATA_W: read data.
- rsp_valid out 1: one-cycle completion pulse.
- rsp_rdata out DATA_W: extended load data; 0 for stores and errors.
- rsp_err out 1: misaligned-with-SPLIT_EN=0, or illegal size.

Behaviour:
- Reset (async, rst_n=0): state IDLE. bus_valid, bus_we, bus_be, rsp_valid, rsp_err = 0. bus_addr, bus_wdata, rsp_rdata = 0. req_ready = 0 while rst_n is low.
- States: IDLE, CMD0, RD0, CMD1, RD1, RESP.
- IDLE: req_ready=1. On req_valid, latch the request and compute:
  - off = addr[OW-1:0], nbytes = 1<<size.
  - mask2 = ((1<<nbytes)-1) << off, 2*NB bits wide.
  - wide = wdata << (8*off), 2*DATA_W bits wide.
  - beat0 = low halves of mask2/wide; beat1 = high halves.
  - cross = |mask2[2NB-1:NB].
- Error check: if size > OW, or (cross and SPLIT_EN=0), go to RESP with err=1. No bus activity occurs.
- Otherwise go to CMD0.
- CMD0: bus_valid=1, bus_addr = addr with low OW bits cleared, bus_be = beat0 mask, bus_wdata = beat0 data.
  - Outputs hold stable until bus_ready.
  - On acceptance: load -> RD0; store -> CMD1 if cross, else RESP.
- RD0: capture bus_rdata as r0 on bus_rvalid; then CMD1 if cross, else RESP.
- CMD1: as CMD0, using bus_addr + NB and beat1 mask/data.
  - On acceptance: load -> RD1; store -> RESP.
- RD1: capture r1 on bus_rvalid, then go to RESP.
- Read data is ignored outside RD0/RD1; bus_rvalid in those states may coincide with the acceptance cycle of nothing else.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - Load data = ({r1,r0} >> 8*off), truncated to nbytes.
  - Sign-extend from bit 8*nbytes-1 if req_signed, else zero-extend.
  - A full-width load passes data unchanged.
- Latency (zero-wait bus, rvalid the cycle after acceptance):
  - aligned store: 2 cycles request-to-rsp; aligned load: 3.
  - split store: 3; split load: 5.
  - error: 1.
- Next request can be accepted the cycle after RESP. There is no back-to-back overlap.
- bus_valid is never withdrawn before bus_ready.
- Reset asserted mid-transaction aborts immediately to IDLE with no response; the memory side must also be reset.
- Address wrap: bus_addr + NB wraps modulo 2^ADDR_W.

Decomposition:
- Shared package mem_pkg: size encodings SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3; state encoding; NB/OW helper functions.
- One natural sub-module: mem_lane_ext, combinational. It takes {r1,r0}, off, size and signed, and produces extended load data. It is reusable by the single-cycle datapath.

Test Plan:
- DATA_W=32, store byte, addr 0x1003, wdata 0x000000AB -> one beat: bus_addr 0x1000, be 4'b1000, wdata 0xAB000000; rsp_err=0.
- Store half, addr 0x2002, wdata 0x1234 -> be 4'b1100, wdata 0x12340000. With bus_ready held low 3 cycles, bus outputs stay stable throughout.
- Load signed byte, addr 0x3001, rdata 0x0000_80FF -> rsp_rdata 0xFFFFFF80. Same access unsigned -> 0x00000080.
- SPLIT_EN=1, load word, addr 0x4003, beat0 rdata 0x11223344, beat1 rdata 0x55667788 -> two beats with be 1000 and 0111 at 0x4000 and 0x4004; rsp_rdata 0x66778811.
- SPLIT_EN=0, store word at 0x4002 -> no bus_valid; rsp_valid and rsp_err=1 one cycle after accept. Size 3 with DATA_W=32 gives the same error.
- Assert rst_n low during CMD1 of a split store -> all outputs 0 asynchronously, no rsp_valid. After release, req_ready=1 and a fresh aligned word store completes normally.
